// File: rtl/pwm_multi_if.sv
// Register write bus for pwm_multi: one-cycle write strobe with channel,
// register select and data. The peripheral bus side is the master.
interface pwm_multi_if #(
    parameter int NCH = 4,
    parameter int CW  = 16
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic           wr_en;
    logic [CHW-1:0] wr_ch;
    logic [1:0]     wr_sel;
    logic [CW-1:0]  wr_data;

    modport master (output wr_en, wr_ch, wr_sel, wr_data);
    modport slave  (input  wr_en, wr_ch, wr_sel, wr_data);
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: shared period counter, per-channel compare/mode registers.
// Define PWM_SHADOW_EN to buffer register writes in shadows that load on wrap or while stopped.
module pwm_multi #(
    parameter int NCH = 4,
    parameter int CW  = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    pwm_multi_if.slave     wr,
    output logic [NCH-1:0] pwm_out,
    output logic [CW-1:0]  cnt,
    output logic           period_tick
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [CW-1:0]  cnt_reg;
    logic [CW-1:0]  period_reg;
    logic           period_tick_reg;
    logic [NCH-1:0] pwm_out_reg;
    logic [NCH-1:0] out_next;
    logic           wrap;
    logic           period_wr;

    assign wrap      = en && (cnt_reg == period_reg);
    assign period_wr = wr.wr_en && (wr.wr_sel == 2'd3);

    // A lowered period below cnt is never matched, so cnt rolls over naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg         <= '0;
            period_tick_reg <= 1'b0;
        end else begin
            period_tick_reg <= wrap;
            if (en) begin
                cnt_reg <= wrap ? '0 : cnt_reg + CW'(1);
            end
        end
    end

`ifdef PWM_SHADOW_EN
    logic          load;
    logic [CW-1:0] period_sh_reg;

    assign load = wrap || !en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_sh_reg <= '1;
            period_reg    <= '1;
        end else begin
            if (period_wr) begin
                period_sh_reg <= wr.wr_data;
            end
            if (load) begin
                period_reg <= period_sh_reg;
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_reg <= '1;
        end else if (period_wr) begin
            period_reg <= wr.wr_data;
        end
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [CW-1:0] cmp1_reg;
            logic [CW-1:0] cmp2_reg;
            logic [1:0]    mode_reg;
            logic          sel_ch;
            logic          cmp1_wr;
            logic          cmp2_wr;
            logic          mode_wr;
            logic          level;

            // Out-of-range channel numbers never match any gi, so those writes drop.
            assign sel_ch  = wr.wr_en && (wr.wr_ch == CHW'(gi));
            assign cmp1_wr = sel_ch && (wr.wr_sel == 2'd0);
            assign cmp2_wr = sel_ch && (wr.wr_sel == 2'd1);
            assign mode_wr = sel_ch && (wr.wr_sel == 2'd2);

`ifdef PWM_SHADOW_EN
            logic [CW-1:0] cmp1_sh_reg;
            logic [CW-1:0] cmp2_sh_reg;
            logic [1:0]    mode_sh_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cmp1_sh_reg <= '0;
                    cmp2_sh_reg <= '0;
                    mode_sh_reg <= 2'b11;
                    cmp1_reg    <= '0;
                    cmp2_reg    <= '0;
                    mode_reg    <= 2'b11;
                end else begin
                    if (cmp1_wr) cmp1_sh_reg <= wr.wr_data;
                    if (cmp2_wr) cmp2_sh_reg <= wr.wr_data;
                    if (mode_wr) mode_sh_reg <= wr.wr_data[1:0];
                    // A write on the wrap edge lands in the shadow only; active takes the old shadow.
                    if (load) begin
                        cmp1_reg <= cmp1_sh_reg;
                        cmp2_reg <= cmp2_sh_reg;
                        mode_reg <= mode_sh_reg;
                    end
                end
            end
`else
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cmp1_reg <= '0;
                    cmp2_reg <= '0;
                    mode_reg <= 2'b11;
                end else begin
                    if (cmp1_wr) cmp1_reg <= wr.wr_data;
                    if (cmp2_wr) cmp2_reg <= wr.wr_data;
                    if (mode_wr) mode_reg <= wr.wr_data[1:0];
                end
            end
`endif

            // Window mode yields 0 by construction whenever cmp2 <= cmp1.
            always_comb begin
                level = 1'b0;
                case (mode_reg)
                    2'b00:   level = (cnt_reg < cmp1_reg);
                    2'b01:   level = (cnt_reg >= cmp1_reg);
                    2'b10:   level = (cnt_reg >= cmp1_reg) && (cnt_reg < cmp2_reg);
                    default: level = 1'b0;
                endcase
            end

            assign out_next[gi] = level;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out_reg <= '0;
        end else if (en) begin
            pwm_out_reg <= out_next;
        end
    end

    assign pwm_out     = pwm_out_reg;
    assign cnt         = cnt_reg;
    assign period_tick = period_tick_reg;
endmodule
